v_tag_verify_64: RTL and testbench

V_TAG_VERIFY_64 -- requirements
Module: v_tag_verify_64

---
 rtl/v_tag_verify_64.sv | 121 ++++++++++++
 tb/tb_v_tag_verify_64.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/v_tag_verify_64.sv
// Tag verifier: folds 64-bit plaintext blocks into a three-lane GF(2^64)
// checksum, captures the received tag and produces a registered pass/fail verdict.
module v_tag_verify_64 #(
  parameter logic [63:0] BETA = 64'h1B
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic         blk_valid,
  output logic         blk_ready,
  input  logic [63:0]  blk_data,
  input  logic         blk_last,
  input  logic         tag_valid,
  input  logic [191:0] tag_data,
  output logic         busy,
  output logic         done,
  output logic         pass,
  output logic [191:0] checksum,
  output logic [15:0]  blk_count,
  output logic         err_ovf
);

  typedef enum logic [2:0] {IDLE, ACCUM, WAIT_TAG, COMPARE, DONE} state_e;

  state_e        state_q, state_d;
  logic [63:0]   lane0_q, lane0_d, lane1_q, lane1_d, lane2_q, lane2_d;
  logic [191:0]  tag_q, tag_d;
  logic [15:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d, pass_q, pass_d, done_q, done_d;
  logic          accept;

  // Multiply by x in GF(2^64), reducing by BETA on carry-out
  function automatic logic [63:0] xtime(input logic [63:0] c);
    xtime = {c[62:0], 1'b0} ^ (c[63] ? BETA : 64'h0);
  endfunction

  assign accept    = (state_q == ACCUM) && blk_valid;
  assign blk_ready = (state_q == ACCUM);
  assign busy      = (state_q != IDLE) && (state_q != DONE);
  assign done      = done_q;
  assign pass      = pass_q;
  assign checksum  = {lane2_q, lane1_q, lane0_q};
  assign blk_count = cnt_q;
  assign err_ovf   = ovf_q;

  // Next-state and datapath updates; done pulses only on COMPARE->DONE
  always_comb begin
    state_d = state_q;
    lane0_d = lane0_q;
    lane1_d = lane1_q;
    lane2_d = lane2_q;
    tag_d   = tag_q;
    cnt_d   = cnt_q;
    ovf_d   = ovf_q;
    pass_d  = pass_q;
    done_d  = 1'b0;
    case (state_q)
      IDLE, DONE: begin
        if (start) begin
          lane0_d = '0;
          lane1_d = '0;
          lane2_d = '0;
          tag_d   = '0;
          cnt_d   = '0;
          ovf_d   = 1'b0;
          pass_d  = 1'b0;
          state_d = ACCUM;
        end
      end
      ACCUM: begin
        if (accept) begin
          lane0_d = lane0_q ^ blk_data;
          lane1_d = xtime(lane1_q) ^ blk_data;
          lane2_d = xtime(xtime(lane2_q)) ^ blk_data;
          // Saturate rather than wrap so the overflow poisons the verdict
          if (cnt_q == 16'hFFFF) ovf_d = 1'b1;
          else                   cnt_d = cnt_q + 16'd1;
          if (blk_last) state_d = WAIT_TAG;
        end
      end
      WAIT_TAG: begin
        if (tag_valid) begin
          tag_d   = tag_data;
          state_d = COMPARE;
        end
      end
      COMPARE: begin
        pass_d  = !ovf_q && ({lane2_q, lane1_q, lane0_q} == tag_q);
        done_d  = 1'b1;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lane0_q <= '0;
      lane1_q <= '0;
      lane2_q <= '0;
      tag_q   <= '0;
      cnt_q   <= '0;
      ovf_q   <= 1'b0;
      pass_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      lane0_q <= lane0_d;
      lane1_q <= lane1_d;
      lane2_q <= lane2_d;
      tag_q   <= tag_d;
      cnt_q   <= cnt_d;
      ovf_q   <= ovf_d;
      pass_q  <= pass_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_v_tag_verify_64.sv
// Directed bench for v_tag_verify_64 with a small reference checksum model.
module tb_v_tag_verify_64;
  logic         clk = 1'b0;
  logic         rst_n, start, blk_valid, blk_ready, blk_last, tag_valid;
  logic [63:0]  blk_data;
  logic [191:0] tag_data;
  logic         busy, done, pass, err_ovf;
  logic [191:0] checksum;
  logic [15:0]  blk_count;

  int n_chk = 0;
  int n_err = 0;
  logic [63:0] m0, m1, m2;

  v_tag_verify_64 dut (
    .clk(clk), .rst_n(rst_n), .start(start), .blk_valid(blk_valid),
    .blk_ready(blk_ready), .blk_data(blk_data), .blk_last(blk_last),
    .tag_valid(tag_valid), .tag_data(tag_data), .busy(busy), .done(done),
    .pass(pass), .checksum(checksum), .blk_count(blk_count), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] xt(input logic [63:0] c);
    xt = (c << 1) ^ (c[63] ? 64'h1B : 64'h0);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    m0 = '0; m1 = '0; m2 = '0;
  endtask

  task automatic send_block(input logic [63:0] d, input logic last);
    blk_valid = 1'b1; blk_data = d; blk_last = last; tag_valid = 1'b0;
    step();
    blk_valid = 1'b0; blk_last = 1'b0;
    m0 = m0 ^ d;
    m1 = xt(m1) ^ d;
    m2 = xt(xt(m2)) ^ d;
  endtask

  task automatic send_tag(input logic [191:0] t);
    tag_valid = 1'b1; tag_data = t;
    step();
    tag_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b1;
    step(); step();
    start = 1'b0;
    n_chk++;
    if ({done, pass, err_ovf, blk_ready, busy} !== 5'b0) begin
      n_err++; $display("FAIL reset_flags got %b want 00000", {done, pass, err_ovf, blk_ready, busy});
    end
    n_chk++;
    if (checksum !== 192'h0 || blk_count !== 16'h0) begin
      n_err++; $display("FAIL reset_data got cs=%h cnt=%h want 0", checksum, blk_count);
    end
    rst_n = 1'b1;
    step();
    n_chk++;
    if (busy !== 1'b0 || blk_ready !== 1'b0) begin
      n_err++; $display("FAIL idle_no_start got busy=%b ready=%b want 0 0", busy, blk_ready);
    end
  endtask

  task automatic test_single();
    do_start();
    n_chk++;
    if (busy !== 1'b1 || blk_ready !== 1'b1 || blk_count !== 16'h0) begin
      n_err++; $display("FAIL accum_entry got busy=%b ready=%b cnt=%h want 1 1 0", busy, blk_ready, blk_count);
    end
    send_block(64'h1, 1'b1);
    n_chk++;
    if (checksum !== {64'h1, 64'h1, 64'h1} || blk_count !== 16'h1 || blk_ready !== 1'b0) begin
      n_err++; $display("FAIL single_cs got cs=%h cnt=%h rdy=%b want 1/1/1 1 0", checksum, blk_count, blk_ready);
    end
    send_tag({64'h1, 64'h1, 64'h1});
    n_chk++;
    if (done !== 1'b0) begin
      n_err++; $display("FAIL done_early got %b want 0", done);
    end
    step();
    n_chk++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_err++; $display("FAIL single_verdict got done=%b pass=%b want 1 1", done, pass);
    end
    step();
    n_chk++;
    if (done !== 1'b0 || pass !== 1'b1 || busy !== 1'b0) begin
      n_err++; $display("FAIL done_pulse got done=%b pass=%b busy=%b want 0 1 0", done, pass, busy);
    end
  endtask

  task automatic test_two_blocks();
    do_start();
    n_chk++;
    if (pass !== 1'b0) begin
      n_err++; $display("FAIL start_clears_pass got %b want 0", pass);
    end
    send_block(64'h1, 1'b0);
    send_block(64'h1, 1'b1);
    n_chk++;
    if (checksum !== {64'h5, 64'h3, 64'h0}) begin
      n_err++; $display("FAIL two_blk_cs got %h want 5/3/0", checksum);
    end
    send_tag({64'h5, 64'h3, 64'h1});
    step();
    n_chk++;
    if (done !== 1'b1 || pass !== 1'b0) begin
      n_err++; $display("FAIL two_blk_mismatch got done=%b pass=%b want 1 0", done, pass);
    end
    step();
  endtask

  task automatic test_reduction();
    do_start();
    send_block(64'h8000_0000_0000_0000, 1'b0);
    send_block(64'h0, 1'b1);
    n_chk++;
    if (checksum !== {64'h36, 64'h1B, 64'h8000_0000_0000_0000}) begin
      n_err++; $display("FAIL red_lane1 got %h want 36/1b/8000..", checksum);
    end
    send_tag('0); step(); step();
    do_start();
    send_block(64'h4000_0000_0000_0000, 1'b0);
    send_block(64'h0, 1'b1);
    n_chk++;
    if (checksum !== {64'h1B, 64'h8000_0000_0000_0000, 64'h4000_0000_0000_0000}) begin
      n_err++; $display("FAIL red_lane2 got %h want 1b/8000../4000..", checksum);
    end
    send_tag('0); step(); step();
  endtask

  task automatic test_gaps();
    logic [63:0] blks [4] = '{64'hDEAD_BEEF_0123_4567, 64'hFFFF_FFFF_FFFF_FFFF,
                              64'h8000_0000_0000_0001, 64'h0F0F_0000_A5A5_5A5A};
    do_start();
    for (int i = 0; i < 4; i++) begin
      int gap = int'($urandom_range(1, 3));
      for (int g = 0; g < gap; g++) begin
        tag_valid = 1'b1; tag_data = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
        start = (g == 0);
        step();
        start = 1'b0;
      end
      tag_valid = 1'b0;
      n_chk++;
      if (blk_ready !== 1'b1 || blk_count !== 16'(i)) begin
        n_err++; $display("FAIL gap_stall got rdy=%b cnt=%h want 1 %h", blk_ready, blk_count, i[15:0]);
      end
      send_block(blks[i], i == 3);
    end
    n_chk++;
    if (checksum !== {m2, m1, m0}) begin
      n_err++; $display("FAIL gap_cs got %h want %h", checksum, {m2, m1, m0});
    end
    step(); step();
    n_chk++;
    if (busy !== 1'b1 || done !== 1'b0) begin
      n_err++; $display("FAIL wait_tag_hold got busy=%b done=%b want 1 0", busy, done);
    end
    send_tag({m2, m1, m0});
    step();
    n_chk++;
    if (done !== 1'b1 || pass !== 1'b1) begin
      n_err++; $display("FAIL gap_verdict got done=%b pass=%b want 1 1", done, pass);
    end
    step();
  endtask

  task automatic test_reset_mid();
    do_start();
    send_block(64'h11, 1'b0);
    send_block(64'h22, 1'b0);
    send_block(64'h33, 1'b0);
    rst_n = 1'b0; blk_valid = 1'b1; blk_data = 64'h44; blk_last = 1'b1;
    step();
    rst_n = 1'b1; blk_valid = 1'b0; blk_last = 1'b0;
    n_chk++;
    if ({done, pass, err_ovf, blk_ready, busy} !== 5'b0 || checksum !== 192'h0 || blk_count !== 16'h0) begin
      n_err++; $display("FAIL mid_reset got flags=%b cs=%h cnt=%h want all 0",
                        {done, pass, err_ovf, blk_ready, busy}, checksum, blk_count);
    end
    step(); step();
    n_chk++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_err++; $display("FAIL mid_reset_idle got done=%b busy=%b want 0 0", done, busy);
    end
  endtask

  task automatic test_overflow();
    do_start();
    for (int i = 0; i < 65537; i++) begin
      send_block(64'(i) * 64'h9E37_79B9_7F4A_7C15, i == 65536);
      if (i == 65534) begin
        n_chk++;
        if (blk_count !== 16'hFFFF || err_ovf !== 1'b0) begin
          n_err++; $display("FAIL ovf_edge got cnt=%h ovf=%b want ffff 0", blk_count, err_ovf);
        end
      end
    end
    n_chk++;
    if (blk_count !== 16'hFFFF || err_ovf !== 1'b1) begin
      n_err++; $display("FAIL ovf_sat got cnt=%h ovf=%b want ffff 1", blk_count, err_ovf);
    end
    n_chk++;
    if (checksum !== {m2, m1, m0}) begin
      n_err++; $display("FAIL ovf_cs got %h want %h", checksum, {m2, m1, m0});
    end
    send_tag({m2, m1, m0});
    step();
    n_chk++;
    if (done !== 1'b1 || pass !== 1'b0) begin
      n_err++; $display("FAIL ovf_verdict got done=%b pass=%b want 1 0", done, pass);
    end
    step();
    do_start();
    n_chk++;
    if (err_ovf !== 1'b0 || blk_count !== 16'h0) begin
      n_err++; $display("FAIL ovf_clear got ovf=%b cnt=%h want 0 0", err_ovf, blk_count);
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; blk_valid = 1'b0; blk_last = 1'b0;
    blk_data = '0; tag_valid = 1'b0; tag_data = '0;
    m0 = '0; m1 = '0; m2 = '0;
    test_reset();
    test_single();
    test_two_blocks();
    test_reduction();
    test_gaps();
    test_reset_mid();
    test_overflow();
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
